mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
//   Accepts one instruction at a time from execute. Non-memory ops are
//   forwarded to write-back one cycle later. Aligned word loads/stores issue
//   a held, registered request to data memory and wait for dmem_ack, bounded
//   by TIMEOUT request cycles. Misaligned accesses and timeouts return a
//   "no register write" result (optype 6'h3F) together with err_pulse.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               execute-side handshake
//   in_optype, in_regaddr3,
//   in_alu_result, in_store_data    instruction payload
//   dmem_req/we/addr/wdata          data memory request (registered)
//   dmem_ack, dmem_rdata            data memory completion
//   out_valid, out_optype,
//   out_regaddr3, out_regdata       write-back result (registered)
//   err_pulse                       one-cycle error indication
module mem_access #(
    parameter logic [5:0] LD_OPTYPE = 6'h13,
    parameter logic [5:0] ST_OPTYPE = 6'h14,
    parameter int         TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_optype,
    input  logic [4:0]  in_regaddr3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [5:0]  out_optype,
    output logic [4:0]  out_regaddr3,
    output logic [31:0] out_regdata,
    output logic        err_pulse
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [5:0]  NOWRITE_OPTYPE = 6'h3F;
    localparam logic [31:0] REGDATA_RESET  = 32'hCCCC_CCCC;
    localparam logic [7:0]  CNT_LAST       = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [5:0]  cap_optype_q, cap_optype_d;
    logic [4:0]  cap_regaddr_q, cap_regaddr_d;
    logic        out_valid_q, out_valid_d;
    logic [5:0]  out_optype_q, out_optype_d;
    logic [4:0]  out_regaddr3_q, out_regaddr3_d;
    logic [31:0] out_regdata_q, out_regdata_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        is_mem_s;
    logic        misaligned_s;

    assign in_ready     = (state_q == IDLE);
    assign accept_s     = in_valid & in_ready;
    assign is_mem_s     = (in_optype == LD_OPTYPE) || (in_optype == ST_OPTYPE);
    assign misaligned_s = (in_alu_result[1:0] != 2'b00);

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_optype   = out_optype_q;
    assign out_regaddr3 = out_regaddr3_q;
    assign out_regdata  = out_regdata_q;
    assign err_pulse    = err_q;

    // Next-state and registered-output logic for the IDLE/ACCESS FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        cap_optype_d   = cap_optype_q;
        cap_regaddr_d  = cap_regaddr_q;
        out_valid_d    = 1'b0;
        out_optype_d   = NOWRITE_OPTYPE;   // idle value whenever out_valid is low
        out_regaddr3_d = out_regaddr3_q;
        out_regdata_d  = out_regdata_q;
        err_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (!is_mem_s) begin
                        out_valid_d    = 1'b1;
                        out_optype_d   = in_optype;
                        out_regaddr3_d = in_regaddr3;
                        out_regdata_d  = in_alu_result;
                    end else if (misaligned_s) begin
                        // No memory request; report a non-writing result.
                        out_valid_d    = 1'b1;
                        out_optype_d   = NOWRITE_OPTYPE;
                        out_regaddr3_d = in_regaddr3;
                        out_regdata_d  = in_alu_result;
                        err_d          = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        cnt_d         = 8'd0;
                        dmem_req_d    = 1'b1;
                        dmem_we_d     = (in_optype == ST_OPTYPE);
                        dmem_addr_d   = in_alu_result;
                        dmem_wdata_d  = in_store_data;
                        cap_optype_d  = in_optype;
                        cap_regaddr_d = in_regaddr3;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (dmem_ack) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    out_valid_d    = 1'b1;
                    out_optype_d   = cap_optype_q;
                    out_regaddr3_d = cap_regaddr_q;
                    if (cap_optype_q == LD_OPTYPE) begin
                        out_regdata_d = dmem_rdata;
                    end else begin
                        out_regdata_d = dmem_addr_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    out_valid_d    = 1'b1;
                    out_optype_d   = NOWRITE_OPTYPE;
                    out_regaddr3_d = cap_regaddr_q;
                    err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            cap_optype_q   <= NOWRITE_OPTYPE;
            cap_regaddr_q  <= 5'd0;
            out_valid_q    <= 1'b0;
            out_optype_q   <= NOWRITE_OPTYPE;
            out_regaddr3_q <= 5'd0;
            out_regdata_q  <= REGDATA_RESET;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            cap_optype_q   <= cap_optype_d;
            cap_regaddr_q  <= cap_regaddr_d;
            out_valid_q    <= out_valid_d;
            out_optype_q   <= out_optype_d;
            out_regaddr3_q <= out_regaddr3_d;
            out_regdata_q  <= out_regdata_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU forwarding, back-to-back issue, load,
// store, misaligned access, timeout, ack-at-timeout and reset mid-access.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_optype;
    logic [4:0]  in_regaddr3;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [5:0]  out_optype;
    logic [4:0]  out_regaddr3;
    logic [31:0] out_regdata;
    logic        err_pulse;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_optype(in_optype), .in_regaddr3(in_regaddr3),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_optype(out_optype),
        .out_regaddr3(out_regaddr3), .out_regdata(out_regdata),
        .err_pulse(err_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] ra,
                         input logic [31:0] alu, input logic [31:0] sd);
        in_valid      = 1'b1;
        in_optype     = op;
        in_regaddr3   = ra;
        in_alu_result = alu;
        in_store_data = sd;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_optype = 6'h0; in_regaddr3 = 5'd0;
        in_alu_result = 32'd0; in_store_data = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        tick(); tick();
        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err_pulse), 32'd0);
        check("rst_optype", 32'(out_optype), 32'h3F);
        check("rst_regaddr", 32'(out_regaddr3), 32'd0);
        check("rst_regdata", out_regdata, 32'hCCCC_CCCC);
        rst_n = 1'b1;
        tick();

        // ALU op, then a second ALU op back to back
        issue(6'h00, 5'd5, 32'h1234, 32'd0);
        tick();
        check("alu_valid", 32'(out_valid), 32'd1);
        check("alu_data", out_regdata, 32'h1234);
        check("alu_regaddr", 32'(out_regaddr3), 32'd5);
        check("alu_optype", 32'(out_optype), 32'h00);
        check("alu_err", 32'(err_pulse), 32'd0);
        check("b2b_ready", 32'(in_ready), 32'd1);
        issue(6'h02, 5'd7, 32'h55, 32'd0);
        tick();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data", out_regdata, 32'h55);
        check("b2b_optype", 32'(out_optype), 32'h02);
        in_valid = 1'b0;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_optype", 32'(out_optype), 32'h3F);

        // Ack while idle is ignored
        dmem_ack = 1'b1;
        tick();
        check("idle_ack_valid", 32'(out_valid), 32'd0);
        check("idle_ack_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;

        // Load at 0x40, ack in the 3rd request cycle
        issue(6'h13, 5'd3, 32'h40, 32'd0);
        tick();
        in_valid = 1'b0;
        check("ld_req1", 32'(dmem_req), 32'd1);
        check("ld_we", 32'(dmem_we), 32'd0);
        check("ld_addr", dmem_addr, 32'h40);
        check("ld_ready", 32'(in_ready), 32'd0);
        check("ld_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("ld_req2", 32'(dmem_req), 32'd1);
        tick();
        check("ld_req3", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_ack = 1'b0;
        check("ld_req_drop", 32'(dmem_req), 32'd0);
        check("ld_valid", 32'(out_valid), 32'd1);
        check("ld_data", out_regdata, 32'hDEADBEEF);
        check("ld_optype", 32'(out_optype), 32'h13);
        check("ld_regaddr", 32'(out_regaddr3), 32'd3);
        check("ld_err", 32'(err_pulse), 32'd0);
        tick();
        check("ld_single_valid", 32'(out_valid), 32'd0);

        // Store at 0x80, ack on first request cycle
        issue(6'h14, 5'd9, 32'h80, 32'hA5A5A5A5);
        tick();
        in_valid = 1'b0;
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
        check("st_addr", dmem_addr, 32'h80);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_valid", 32'(out_valid), 32'd1);
        check("st_optype", 32'(out_optype), 32'h14);
        check("st_data", out_regdata, 32'h80);
        check("st_req_drop", 32'(dmem_req), 32'd0);

        // Misaligned load at 0x41
        issue(6'h13, 5'd4, 32'h41, 32'd0);
        tick();
        in_valid = 1'b0;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_valid", 32'(out_valid), 32'd1);
        check("mis_err", 32'(err_pulse), 32'd1);
        check("mis_optype", 32'(out_optype), 32'h3F);
        check("mis_regaddr", 32'(out_regaddr3), 32'd4);
        tick();
        check("mis_err_once", 32'(err_pulse), 32'd0);

        // Load with no ack: request held for exactly TIMEOUT cycles
        issue(6'h13, 5'd6, 32'h100, 32'd0);
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd16);
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_err", 32'(err_pulse), 32'd1);
        check("to_optype", 32'(out_optype), 32'h3F);
        tick();
        check("to_err_once", 32'(err_pulse), 32'd0);

        // Ack in the 16th request cycle wins over timeout
        issue(6'h13, 5'd8, 32'h200, 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("ackto_req16", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h600DF00D;
        tick();
        dmem_ack = 1'b0;
        check("ackto_valid", 32'(out_valid), 32'd1);
        check("ackto_err", 32'(err_pulse), 32'd0);
        check("ackto_data", out_regdata, 32'h600DF00D);
        check("ackto_optype", 32'(out_optype), 32'h13);
        tick();
        check("ackto_err_after", 32'(err_pulse), 32'd0);

        // Reset during the 2nd access cycle
        issue(6'h13, 5'd2, 32'h300, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("rsta_req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rsta_req", 32'(dmem_req), 32'd0);
        check("rsta_valid", 32'(out_valid), 32'd0);
        check("rsta_err", 32'(err_pulse), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rsta_ready", 32'(in_ready), 32'd1);
        check("rsta_valid_after", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
